regfile_mp_sb: RTL
==================

Name: regfile_mp_sb

Overview:
- Parametrised multi-port integer register file for the pipelined RISC-V core.
- Replaces the single-cycle 2R/1W register file.
- Adds configurable width, depth, read-port and write-port counts, write-to-read bypass, asynchronous clear and a per-register busy scoreboard for hazard detection.
- Sits between decode (reads, issue) and writeback (writes, scoreboard release).

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; power of two, at least 2.
- NRD, 2, number of read ports, 1 to 4.
- NWR, 1, number of write ports, 1 to 2.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching reads.
- ZERO_REG, 1, when 1 register 0 reads as zero and ignores writes and busy sets.
- AW, localparam, equals $clog2(NREGS).

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- rd_addr, input, NRD*AW, read addresses; port k uses bits [k*AW +: AW].
- rd_data, output, NRD*XLEN, read data per port, combinational.
- rd_busy, output, NRD, scoreboard busy flag of each addressed register, combinational.
- we, input, NWR, write enable per write port.
- wa, input, NWR*AW, write addresses.
- wd, input, NWR*XLEN, write data.
- wclr, input, NWR, when set with we, the write also clears the busy bit of wa.
- iss_valid, input, 1, an instruction with a destination issues this cycle.
- iss_rd, input, AW, destination register of the issuing instruction.
- busy_vec, output, NREGS, registered busy bits; bit i is register i.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst_n is asynchronous and active-low.
  - Asserting rst_n low immediately clears every register and every busy bit to 0.
  - On deassertion, updates resume at the next rising edge.
  - Reset asserted mid-operation discards pending writes and issues in that cycle.
- Reset values of outputs: busy_vec = 0, rd_busy = 0, rd_data = 0 for every address.
- Writes:
  - Synchronous.
  - At the edge, for each port j with we[j]=1, register wa[j] takes wd[j].
  - If ZERO_REG=1 and wa[j]=0, the write is dropped.
- Write conflict: if NWR=2, both ports enabled and wa[0]==wa[1], port 1 wins; port 0 data is discarded.
- Reads:
  - Combinational, zero latency.
  - If ZERO_REG=1 and the address is 0, rd_data=0 and rd_busy=0.
- Bypass (BYPASS=1):
  - If a read address matches an enabled write address in the same cycle, rd_data returns that wd instead of stored data.
  - Highest-index write port has priority, consistent with the write conflict rule.
  - Zero-register rule takes precedence over bypass.
  - BYPASS=0: reads return stored data only; the new value is visible the cycle after the write edge.
- Scoreboard, at each edge per register i:
  - set_i = iss_valid and iss_rd==i, excluding i=0 when ZERO_REG=1.
  - clr_i = OR over j of (we[j] and wclr[j] and wa[j]==i).
  - Next busy_i = set_i ? 1 : (clr_i ? 0 : busy_i).
  - Simultaneous set and clear on the same register: set wins, because the new producer supersedes the retiring one.
- rd_busy:
  - Reflects registered busy bits only; it is not bypassed.
  - With BYPASS=1, a consumer reading while the producer's clearing write is on the port gets correct data. It is the hazard unit's job to qualify rd_busy with the bypass match; this block does not do so.
- Arithmetic and width:
  - Addresses are unsigned; no out-of-range addresses exist since NREGS = 2^AW.
  - Data is stored unmodified.
- No internal FSM beyond the register and busy arrays; all sequential state is XLEN*NREGS + NREGS flops.

Decomposition:
- Shared package rv_pkg holds XLEN default, NREGS default and the AW computation helper.
- One natural sub-module: regfile_scoreboard, containing the busy array, set/clear priority, busy_vec and rd_busy lookup.
- The data array, write-port priority and bypass muxing stay in regfile_mp_sb.

Test Plan:
1. Reset:
   - Write 0xDEADBEEF to x5, assert rst_n=0 mid-cycle.
   - Read x5 -> 0 immediately (asynchronous); busy_vec=0.
2. Write/read and zero register:
   - we[0]=1, wa=5, wd=0x12345678; next cycle rd_addr0=5 -> 0x12345678.
   - Write 0xFFFFFFFF to x0; read x0 -> 0.
3. Bypass:
   - With BYPASS=1, same cycle we=1, wa=7, wd=0xA5A5A5A5, rd_addr1=7 -> rd_data1=0xA5A5A5A5 combinationally.
   - Repeat with BYPASS=0 -> old value, new value next cycle.
4. Dual-write conflict (NWR=2):
   - Both ports to x9, wd0=0x11, wd1=0x22 -> x9=0x22.
   - Concurrent read of x9 with bypass -> 0x22.
5. Scoreboard:
   - iss_valid with iss_rd=3 -> busy_vec[3]=1 next cycle, rd_busy=1 for reads of x3.
   - Write x3 with wclr=1 -> busy_vec[3]=0 next cycle.
   - Issue x0 -> busy_vec stays 0.
6. Set/clear collision:
   - busy_vec[4]=1; same cycle iss_rd=4 issue and write x4 with wclr=1 -> x4 updated, busy_vec[4] remains 1.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared defaults for the integer register file and the address-width helper
// used to size register indices.
package rv_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;

  function automatic int addr_width(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: issue marks a destination busy, a clearing
// writeback releases it, and read ports look up the registered busy bits.
module regfile_scoreboard
  import rv_pkg::*;
#(
  parameter int NREGS    = NREGS_DEFAULT,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1,
  parameter int AW       = addr_width(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   wa,
  input  logic [NWR-1:0]      wclr,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  output logic [NRD-1:0]      rd_busy,
  output logic [NREGS-1:0]    busy_vec
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] set_vec;
  logic [NREGS-1:0] clr_vec;

  // Set is applied after clear so a new producer supersedes the retiring one.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int j = 0; j < NWR; j++) begin
      if (we[j] && wclr[j]) clr_vec[wa[j*AW +: AW]] = 1'b1;
    end
    if (iss_valid && !(ZERO_REG != 0 && iss_rd == '0)) set_vec[iss_rd] = 1'b1;
    busy_d = (busy_q & ~clr_vec) | set_vec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd_busy
    logic [AW-1:0] addr;
    assign addr = rd_addr[gi*AW +: AW];
    assign rd_busy[gi] = (ZERO_REG != 0 && addr == '0) ? 1'b0 : busy_q[addr];
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with same-cycle write bypass, optional
// hardwired zero register and a busy scoreboard for hazard detection.
module regfile_mp_sb
  import rv_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int NREGS    = NREGS_DEFAULT,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = addr_width(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*XLEN-1:0]   rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*AW-1:0]     wa,
  input  logic [NWR*XLEN-1:0]   wd,
  input  logic [NWR-1:0]        wclr,
  input  logic                  iss_valid,
  input  logic [AW-1:0]         iss_rd,
  output logic [NREGS-1:0]      busy_vec
);

  logic [XLEN-1:0] mem_q [NREGS];
  logic [XLEN-1:0] mem_d [NREGS];

  // Ports are applied in ascending order so the highest port wins a conflict.
  always_comb begin
    mem_d = mem_q;
    for (int j = 0; j < NWR; j++) begin
      if (we[j] && !(ZERO_REG != 0 && wa[j*AW +: AW] == '0)) begin
        mem_d[wa[j*AW +: AW]] = wd[j*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;

    assign addr = rd_addr[gi*AW +: AW];

    // Zero-register masking is applied last so it overrides any bypass hit.
    always_comb begin
      data = mem_q[addr];
      if (BYPASS != 0) begin
        for (int j = 0; j < NWR; j++) begin
          if (we[j] && wa[j*AW +: AW] == addr) data = wd[j*XLEN +: XLEN];
        end
      end
      if (ZERO_REG != 0 && addr == '0) data = '0;
    end

    assign rd_data[gi*XLEN +: XLEN] = data;
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .NRD      (NRD),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr   (rd_addr),
    .we        (we),
    .wa        (wa),
    .wclr      (wclr),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .rd_busy   (rd_busy),
    .busy_vec  (busy_vec)
  );

endmodule
